sixty_four_bit_register_file: RTL and testbench



---
 rtl/sixty_four_bit_register_file_pkg.sv | 14 +
 rtl/sixty_four_bit_register_file_if.sv | 25 ++
 rtl/sixty_four_bit_register_file_read_port.sv | 21 ++
 rtl/sixty_four_bit_register_file.sv | 52 +++++
 tb/tb_sixty_four_bit_register_file.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sixty_four_bit_register_file_pkg.sv
// Shared LEGv8 definitions for the register file and its users.
//   REG_COUNT  : number of architectural registers
//   REG_ADDR_W : register index width
//   XLEN       : register width in bits
//   XZR_ADDR   : index of the zero register (only special when REGFILE_XZR_EN)
package legv8_pkg;
  localparam int        REG_COUNT  = 32;
  localparam int        REG_ADDR_W = 5;
  localparam int        XLEN       = 64;
  localparam logic [4:0] XZR_ADDR  = 5'd31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;
endpackage

// File: rtl/sixty_four_bit_register_file_if.sv
// Register-file access bus: two read addresses/results and one write port.
//   master : drives addresses, write data and reg_write; receives reg_out_1/2
//   slave  : the register file side
interface sixty_four_bit_register_file_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg_address_1;
  logic [ADDR_WIDTH-1:0] read_reg_address_2;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] write_reg_address;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] reg_out_1;
  logic [DATA_WIDTH-1:0] reg_out_2;

  modport master (
    output read_reg_address_1, read_reg_address_2, data, write_reg_address, reg_write,
    input  reg_out_1, reg_out_2
  );

  modport slave (
    input  read_reg_address_1, read_reg_address_2, data, write_reg_address, reg_write,
    output reg_out_1, reg_out_2
  );
endinterface

// File: rtl/sixty_four_bit_register_file_read_port.sv
// regfile_read_port: combinational 2^ADDR_WIDTH:1 read mux over the register array.
//   regs_i : full register array
//   addr_i : register index
//   data_o : selected register (forced to 0 for XZR when REGFILE_XZR_EN is defined)
module regfile_read_port
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]                      addr_i,
  output logic [DATA_WIDTH-1:0]                      data_o
);
  always_comb begin
    data_o = regs_i[addr_i];
`ifdef REGFILE_XZR_EN
    if (addr_i == ADDR_WIDTH'(XZR_ADDR)) data_o = '0;
`endif
  end
endmodule

// File: rtl/sixty_four_bit_register_file.sv
// sixty_four_bit_register_file: LEGv8 register file, 32 x 64-bit.
//   clk   : write clock (rising edge)
//   reset : asynchronous active-high clear of every register
//   bus   : slave side of sixty_four_bit_register_file_if
//           (two combinational read ports, one synchronous write port)
// Optional feature macro: REGFILE_XZR_EN -- register 31 reads as 0 and
// ignores writes (LEGv8 XZR). Without it register 31 is ordinary storage.
// No write-to-read bypass: a pending write becomes visible after the edge.
module sixty_four_bit_register_file
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  sixty_four_bit_register_file_if.slave bus
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic                             wr_blocked;

`ifdef REGFILE_XZR_EN
  assign wr_blocked = (bus.write_reg_address == ADDR_WIDTH'(XZR_ADDR));
`else
  assign wr_blocked = 1'b0;
`endif

  always_comb begin
    regs_d = regs_q;
    if (bus.reg_write && !wr_blocked) regs_d[bus.write_reg_address] = bus.data;
  end

  // Reset wins over a write sampled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd1 (
    .regs_i (regs_q),
    .addr_i (bus.read_reg_address_1),
    .data_o (bus.reg_out_1)
  );

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd2 (
    .regs_i (regs_q),
    .addr_i (bus.read_reg_address_2),
    .data_o (bus.reg_out_2)
  );
endmodule

// File: tb/tb_sixty_four_bit_register_file.sv
// Self-checking bench for sixty_four_bit_register_file. Expected read values
// are pushed to per-port queues when stimulus is driven and popped when the
// outputs are sampled.
module tb_sixty_four_bit_register_file;
  import legv8_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sixty_four_bit_register_file_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) rf_if ();

  sixty_four_bit_register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if.slave)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  xword_t sb1[$];
  xword_t sb2[$];
  xword_t model[32];
  xword_t got, exp_v;

`ifdef REGFILE_XZR_EN
  localparam logic XZR_ON = 1'b1;
`else
  localparam logic XZR_ON = 1'b0;
`endif

  task automatic at_negedge();
    @(negedge clk);
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rf_if.reg_write = 1'b0;
    rf_if.data = '0;
    rf_if.write_reg_address = '0;
    rf_if.read_reg_address_1 = 5'd4;
    rf_if.read_reg_address_2 = 5'd4;
    sb1.push_back(64'd0); sb2.push_back(64'd0);
    after_posedge();
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_out2: got %h want %h", got, exp_v); end
    at_negedge();
    reset = 1'b0;
    #1;
    sb1.push_back(64'd0);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_release: got %h want %h", got, exp_v); end
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic test_write();
    at_negedge();
    rf_if.data = 64'd43;
    rf_if.write_reg_address = 5'd9;
    rf_if.reg_write = 1'b1;
    rf_if.read_reg_address_1 = 5'd4;
    rf_if.read_reg_address_2 = 5'd4;
    #1;
    sb1.push_back(64'd0); sb2.push_back(64'd0);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL write_pre_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL write_pre_out2: got %h want %h", got, exp_v); end
    // Reading the target while its write is pending still sees the old value.
    rf_if.read_reg_address_1 = 5'd9;
    #1;
    sb1.push_back(64'd0);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL no_bypass: got %h want %h", got, exp_v); end
    after_posedge();
    rf_if.reg_write = 1'b0;
    model[9] = 64'd43;
    #1;
    sb1.push_back(64'd43); sb2.push_back(64'd0);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL write_post_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL write_post_out2: got %h want %h", got, exp_v); end
  endtask

  task automatic test_two_ports();
    at_negedge();
    rf_if.data = 64'd3;
    rf_if.write_reg_address = 5'd16;
    rf_if.reg_write = 1'b1;
    after_posedge();
    rf_if.reg_write = 1'b0;
    model[16] = 64'd3;
    rf_if.read_reg_address_1 = 5'd9;
    rf_if.read_reg_address_2 = 5'd16;
    #1;
    sb1.push_back(64'd43); sb2.push_back(64'd3);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL two_ports_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL two_ports_out2: got %h want %h", got, exp_v); end
  endtask

  task automatic test_write_disable();
    at_negedge();
    rf_if.data = 64'hDEAD_BEEF;
    rf_if.write_reg_address = 5'd9;
    rf_if.reg_write = 1'b0;
    rf_if.read_reg_address_1 = 5'd9;
    sb1.push_back(64'd43);
    after_posedge();
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL we_low: got %h want %h", got, exp_v); end
  endtask

  task automatic test_xzr();
    at_negedge();
    rf_if.data = 64'hFFFF_FFFF_FFFF_FFFF;
    rf_if.write_reg_address = 5'd31;
    rf_if.reg_write = 1'b1;
    after_posedge();
    rf_if.reg_write = 1'b0;
    if (!XZR_ON) model[31] = 64'hFFFF_FFFF_FFFF_FFFF;
    rf_if.read_reg_address_1 = 5'd31;
    rf_if.read_reg_address_2 = 5'd31;
    #1;
    exp_v = XZR_ON ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF;
    sb1.push_back(exp_v); sb2.push_back(exp_v);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL xzr_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL xzr_out2: got %h want %h", got, exp_v); end
  endtask

  task automatic test_async_reset();
    at_negedge();
    rf_if.read_reg_address_1 = 5'd9;
    rf_if.read_reg_address_2 = 5'd16;
    #1;
    sb1.push_back(64'd43); sb2.push_back(64'd3);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL areset_pre_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL areset_pre_out2: got %h want %h", got, exp_v); end
    // Mid-cycle pulse: outputs must clear without a clock edge.
    reset = 1'b1;
    #1;
    sb1.push_back(64'd0); sb2.push_back(64'd0);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL areset_out1: got %h want %h", got, exp_v); end
    got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL areset_out2: got %h want %h", got, exp_v); end
    // Write attempted at an edge while reset is held is discarded.
    rf_if.data = 64'd55;
    rf_if.write_reg_address = 5'd9;
    rf_if.reg_write = 1'b1;
    after_posedge();
    at_negedge();
    reset = 1'b0;
    rf_if.reg_write = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    sb1.push_back(64'd0);
    got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset_vs_write: got %h want %h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] wa, ra2;
    xword_t     wd;
    for (int k = 0; k < 24; k++) begin
      at_negedge();
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      ra2 = 5'($urandom_range(0, 31));
      rf_if.data = wd;
      rf_if.write_reg_address = wa;
      rf_if.reg_write = 1'b1;
      rf_if.read_reg_address_1 = wa;
      rf_if.read_reg_address_2 = ra2;
      after_posedge();
      if (!(XZR_ON && wa == 5'd31)) model[wa] = wd;
      sb1.push_back((XZR_ON && wa == 5'd31) ? 64'd0 : model[wa]);
      sb2.push_back((XZR_ON && ra2 == 5'd31) ? 64'd0 : model[ra2]);
      got = rf_if.reg_out_1; exp_v = sb1.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL b2b_out1[%0d] a=%0d: got %h want %h", k, wa, got, exp_v); end
      got = rf_if.reg_out_2; exp_v = sb2.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL b2b_out2[%0d] a=%0d: got %h want %h", k, ra2, got, exp_v); end
    end
    at_negedge();
    rf_if.reg_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_two_ports();
    test_write_disable();
    test_xzr();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
